// File: rtl/contador_nbits_if.sv
// Control/data bundle for the parametrised mode counter.
// The master side drives enable, mode and load data. The slave side (the
// counter) returns the registered count and the wrap pulse.
interface contador_nbits_if #(
    parameter int WIDTH = 4
);
    logic             enb;
    logic [2:0]       modo;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             rco;

    modport master (
        output enb,
        output modo,
        output d,
        input  q,
        input  rco
    );

    modport slave (
        input  enb,
        input  modo,
        input  d,
        output q,
        output rco
    );
endinterface

// File: rtl/contador_nbits.sv
// WIDTH-bit mode counter with clock enable, parallel load, clear, hold and
// step counting. The rco output is a registered one-cycle pulse that marks a
// wrap on the transition that just happened, so it can feed the enable of a
// cascaded stage directly. All arithmetic is modulo 2^WIDTH.
module contador_nbits #(
    parameter int WIDTH = 4,
    parameter int STEP  = 3
) (
    input  logic             clk,
    input  logic             rst,
    contador_nbits_if.slave  bus
);

    typedef enum logic [2:0] {
        MODE_UP1    = 3'b000,
        MODE_DN1    = 3'b001,
        MODE_DNSTEP = 3'b010,
        MODE_LOAD   = 3'b011,
        MODE_UPSTEP = 3'b100,
        MODE_HOLD   = 3'b101,
        MODE_CLEAR  = 3'b110,
        MODE_RSVD   = 3'b111
    } mode_t;

    // Operands are widened by one bit so carry/borrow fall out of the extra
    // MSB without any truncation before the decision is made.
    localparam logic [WIDTH:0] ONE_EXT  = (WIDTH+1)'(1);
    localparam logic [WIDTH:0] STEP_EXT = (WIDTH+1)'(STEP);

    logic [WIDTH-1:0] q_reg;
    logic [WIDTH-1:0] q_next;
    logic             rco_reg;
    logic             rco_next;

    logic [WIDTH:0]   q_ext;
    logic [WIDTH:0]   sum_up1;
    logic [WIDTH:0]   dif_dn1;
    logic [WIDTH:0]   sum_upstep;
    logic [WIDTH:0]   dif_dnstep;
    mode_t            mode;

    assign q_ext      = {1'b0, q_reg};
    assign sum_up1    = q_ext + ONE_EXT;
    assign dif_dn1    = q_ext - ONE_EXT;
    assign sum_upstep = q_ext + STEP_EXT;
    assign dif_dnstep = q_ext - STEP_EXT;
    assign mode       = mode_t'(bus.modo);

    // Next-state selection; disabled edges and non-counting modes hold or
    // clear the count and always drop rco, so the pulse never lingers.
    always_comb begin
        q_next   = q_reg;
        rco_next = 1'b0;
        if (bus.enb) begin
            case (mode)
                MODE_UP1: begin
                    q_next   = sum_up1[WIDTH-1:0];
                    rco_next = sum_up1[WIDTH];
                end
                MODE_DN1: begin
                    q_next   = dif_dn1[WIDTH-1:0];
                    rco_next = dif_dn1[WIDTH];
                end
                MODE_DNSTEP: begin
                    q_next   = dif_dnstep[WIDTH-1:0];
                    rco_next = dif_dnstep[WIDTH];
                end
                MODE_LOAD: begin
                    q_next   = bus.d;
                end
                MODE_UPSTEP: begin
                    q_next   = sum_upstep[WIDTH-1:0];
                    rco_next = sum_upstep[WIDTH];
                end
                MODE_CLEAR: begin
                    q_next   = '0;
                end
                default: begin
                    // Hold and the reserved code both keep the count.
                    q_next   = q_reg;
                end
            endcase
        end
    end

    // State register; reset is asynchronous and overrides any pending update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg   <= '0;
            rco_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            rco_reg <= rco_next;
        end
    end

    assign bus.q   = q_reg;
    assign bus.rco = rco_reg;

endmodule

// File: tb/tb_contador_nbits.sv
// Bench for contador_nbits: directed vector table and hand sequences on a
// WIDTH=4/STEP=3 instance, a WIDTH=8/STEP=100 instance for parametrisation,
// and a randomized run of both against an arithmetic reference model.
module tb_contador_nbits;

    logic clk;
    logic rst_a;
    logic rst_b;

    contador_nbits_if #(.WIDTH(4)) if_a ();
    contador_nbits_if #(.WIDTH(8)) if_b ();

    contador_nbits #(.WIDTH(4), .STEP(3)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (if_a.slave)
    );

    contador_nbits #(.WIDTH(8), .STEP(100)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (if_b.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic       enb;
        logic [2:0] modo;
        logic [3:0] d;
        int         exp_q;
        int         exp_rco;
    } vec_t;

    vec_t vecs [27];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step_a(input logic e, input logic [2:0] m, input logic [3:0] dv);
        if_a.enb  = e;
        if_a.modo = m;
        if_a.d    = dv;
        tick();
    endtask

    task automatic step_b(input logic e, input logic [2:0] m, input logic [7:0] dv);
        if_b.enb  = e;
        if_b.modo = m;
        if_b.d    = dv;
        tick();
    endtask

    // Reference: the counter rules stated as plain integer arithmetic.
    function automatic void model(input int w, input int s, input int q,
                                  input bit e, input int m, input int d,
                                  output int nq, output int nr);
        int modv;
        modv = 1 << w;
        nq = q;
        nr = 0;
        if (e) begin
            case (m)
                0: begin nr = (q + 1 >= modv) ? 1 : 0; nq = (q + 1) % modv; end
                1: begin nr = (q == 0) ? 1 : 0;        nq = (q - 1 + modv) % modv; end
                2: begin nr = (q < s) ? 1 : 0;         nq = (q - s + modv) % modv; end
                3: begin nq = d % modv; end
                4: begin nr = (q + s >= modv) ? 1 : 0; nq = (q + s) % modv; end
                6: begin nq = 0; end
                default: nq = q;
            endcase
        end
    endfunction

    initial begin
        int mq_a, mq_b, nr_a, nr_b, nq_a, nq_b;
        bit re;
        int rm, rda, rdb;

        // {enb, modo, d, expected q, expected rco}, applied from q=3
        vecs[0]  = '{1'b1, 3'b011, 4'd14, 14, 0};
        vecs[1]  = '{1'b1, 3'b000, 4'd0,  15, 0};
        vecs[2]  = '{1'b1, 3'b000, 4'd0,  0,  1};
        vecs[3]  = '{1'b1, 3'b000, 4'd0,  1,  0};
        vecs[4]  = '{1'b1, 3'b011, 4'd2,  2,  0};
        vecs[5]  = '{1'b1, 3'b010, 4'd0,  15, 1};
        vecs[6]  = '{1'b1, 3'b010, 4'd0,  12, 0};
        vecs[7]  = '{1'b1, 3'b110, 4'd9,  0,  0};
        vecs[8]  = '{1'b1, 3'b001, 4'd0,  15, 1};
        vecs[9]  = '{1'b1, 3'b011, 4'd13, 13, 0};
        vecs[10] = '{1'b1, 3'b100, 4'd0,  0,  1};
        vecs[11] = '{1'b1, 3'b100, 4'd0,  3,  0};
        vecs[12] = '{1'b1, 3'b011, 4'd13, 13, 0};
        vecs[13] = '{1'b1, 3'b100, 4'd0,  0,  1};
        vecs[14] = '{1'b1, 3'b011, 4'd15, 15, 0};
        vecs[15] = '{1'b1, 3'b011, 4'd7,  7,  0};
        vecs[16] = '{1'b0, 3'b000, 4'd3,  7,  0};
        vecs[17] = '{1'b0, 3'b100, 4'd3,  7,  0};
        vecs[18] = '{1'b0, 3'b110, 4'd3,  7,  0};
        vecs[19] = '{1'b0, 3'b011, 4'd3,  7,  0};
        vecs[20] = '{1'b1, 3'b101, 4'd3,  7,  0};
        vecs[21] = '{1'b1, 3'b111, 4'd3,  7,  0};
        vecs[22] = '{1'b1, 3'b110, 4'd3,  0,  0};
        vecs[23] = '{1'b1, 3'b001, 4'd0,  15, 1};
        vecs[24] = '{1'b0, 3'b001, 4'd0,  15, 0};
        vecs[25] = '{1'b1, 3'b000, 4'd0,  0,  1};
        vecs[26] = '{1'b1, 3'b000, 4'd0,  1,  0};

        rst_a = 1'b0;
        rst_b = 1'b0;
        if_a.enb = 1'b1; if_a.modo = 3'b000; if_a.d = '0;
        if_b.enb = 1'b0; if_b.modo = 3'b000; if_b.d = '0;

        // Power-on reset, held across a clock edge with enable and up mode
        #1;
        rst_a = 1'b1;
        rst_b = 1'b1;
        #2;
        check("reset_q_a", int'(if_a.q), 0);
        check("reset_rco_a", int'(if_a.rco), 0);
        check("reset_q_b", int'(if_b.q), 0);
        tick();
        check("reset_held_q_a", int'(if_a.q), 0);
        @(negedge clk);
        rst_a = 1'b0;
        rst_b = 1'b0;

        // Async reset clears an in-flight rco pulse before the next edge
        step_a(1'b1, 3'b011, 4'd15);
        step_a(1'b1, 3'b000, 4'd0);
        check("pre_reset_rco", int'(if_a.rco), 1);
        #2;
        rst_a = 1'b1;
        #1;
        check("async_rst_q", int'(if_a.q), 0);
        check("async_rst_rco", int'(if_a.rco), 0);
        @(negedge clk);
        rst_a = 1'b0;

        // Reset mid-count at Q=9 in up mode, then three up edges give 3
        step_a(1'b1, 3'b011, 4'd9);
        check("load9", int'(if_a.q), 9);
        #2;
        rst_a = 1'b1;
        #1;
        check("rst_mid_q", int'(if_a.q), 0);
        check("rst_mid_rco", int'(if_a.rco), 0);
        @(negedge clk);
        rst_a = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            step_a(1'b1, 3'b000, 4'd0);
            check("post_rst_up", int'(if_a.q), i);
        end

        // Directed vector table
        for (int i = 0; i < 27; i++) begin
            step_a(vecs[i].enb, vecs[i].modo, vecs[i].d);
            check($sformatf("vec%0d_q", i), int'(if_a.q), vecs[i].exp_q);
            check($sformatf("vec%0d_rco", i), int'(if_a.rco), vecs[i].exp_rco);
        end
        if_a.enb = 1'b0;

        // WIDTH=8, STEP=100 parametrisation sequence
        step_b(1'b1, 3'b011, 8'd200);
        check("w8_load_q", int'(if_b.q), 200);
        step_b(1'b1, 3'b100, 8'd0);
        check("w8_step1_q", int'(if_b.q), 44);
        check("w8_step1_rco", int'(if_b.rco), 1);
        step_b(1'b1, 3'b100, 8'd0);
        check("w8_step2_q", int'(if_b.q), 144);
        check("w8_step2_rco", int'(if_b.rco), 0);
        step_b(1'b1, 3'b100, 8'd0);
        check("w8_step3_q", int'(if_b.q), 244);
        step_b(1'b1, 3'b100, 8'd0);
        check("w8_step4_q", int'(if_b.q), 88);
        check("w8_step4_rco", int'(if_b.rco), 1);

        // Randomized run of both instances against the reference model
        if_a.enb = 1'b1; if_a.modo = 3'b110;
        if_b.enb = 1'b1; if_b.modo = 3'b110;
        tick();
        check("rand_clear_a", int'(if_a.q), 0);
        check("rand_clear_b", int'(if_b.q), 0);
        mq_a = 0;
        mq_b = 0;
        for (int i = 0; i < 400; i++) begin
            re  = ($urandom_range(0, 3) != 0);
            rm  = int'($urandom_range(0, 7));
            rda = int'($urandom_range(0, 15));
            rdb = int'($urandom_range(0, 255));
            if_a.enb = re; if_a.modo = 3'(rm); if_a.d = 4'(rda);
            if_b.enb = re; if_b.modo = 3'(rm); if_b.d = 8'(rdb);
            model(4, 3, mq_a, re, rm, rda, nq_a, nr_a);
            model(8, 100, mq_b, re, rm, rdb, nq_b, nr_b);
            tick();
            check("rand_q_a", int'(if_a.q), nq_a);
            check("rand_rco_a", int'(if_a.rco), nr_a);
            check("rand_q_b", int'(if_b.q), nq_b);
            check("rand_rco_b", int'(if_b.rco), nr_b);
            mq_a = nq_a;
            mq_b = nq_b;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
